// File: rtl/opb_dec_pkg.sv
// ---------------------------------------------------------------------------
// opb_dec_pkg
// Shared definitions for the OPB region decoder:
//   - state_t      : transfer FSM state encoding
//   - TIMER_W      : width of the wait/timeout timer (covers TIMEOUT up to 255)
//   - ERR_CNT_W    : width of the saturating error counter
//   - MAX_REGIONS  : upper bound on the number of decoded regions
//   - slice_lo()   : low bit of slice idx inside a packed per-region vector
//   - region_onehot(): one-hot select vector for a region index
// ---------------------------------------------------------------------------
package opb_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,  // waiting for RE or WE
        ST_STROBE = 3'd1,  // single-cycle slave strobe is on the bus
        ST_WAIT   = 3'd2,  // waiting for fixed latency or slave ack
        ST_DONE   = 3'd3,  // OPB_ACK pulse
        ST_ERROR  = 3'd4,  // OPB_ACK + OPB_ERR pulse
        ST_HOLD   = 3'd5   // waiting for the master to drop its request
    } state_t;

    localparam int TIMER_W     = 8;
    localparam int ERR_CNT_W   = 8;
    localparam int MAX_REGIONS = 32;

    // Low bit of slice idx in a vector built from equal-width slices,
    // slice 0 in the least significant position.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // One-hot vector with only bit idx set; callers truncate to N_REGIONS.
    function automatic logic [MAX_REGIONS-1:0] region_onehot(input int idx);
        return MAX_REGIONS'(1) << idx;
    endfunction

endpackage : opb_dec_pkg

// File: rtl/opb_region_match.sv
// ---------------------------------------------------------------------------
// opb_region_match
// Combinational hit test for one address region: base <= addr < base+size.
// The comparison is done one bit wider than the address so that a region
// ending at the top of the address space does not wrap. A size of zero
// disables the region.
//
// Ports:
//   addr  in  ADDR_W  byte address under test
//   base  in  ADDR_W  first byte address of the region
//   size  in  ADDR_W  region length in bytes (0 = disabled)
//   hit   out 1       addr falls inside the region
// ---------------------------------------------------------------------------
module opb_region_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    output logic              hit
);

    logic [ADDR_W:0] addr_x;
    logic [ADDR_W:0] lo_x;
    logic [ADDR_W:0] hi_x;

    assign addr_x = {1'b0, addr};
    assign lo_x   = {1'b0, base};
    assign hi_x   = {1'b0, base} + {1'b0, size};

    assign hit = (size != '0) && (addr_x >= lo_x) && (addr_x < hi_x);

endmodule : opb_region_match

// File: rtl/opb_region_decoder.sv
// ---------------------------------------------------------------------------
// opb_region_decoder
// Registered OPB address decoder with N table-driven regions. A request is
// captured in IDLE, the matching slave gets a one-cycle RE/WE strobe, and the
// transfer completes either after a fixed latency or on the slave's ack.
// Unmapped addresses, RE+WE collisions and ack timeouts end in an error
// pulse, latch the offending address and bump a saturating error counter.
//
// Ports:
//   CLK        in   1                 system clock
//   RST_N      in   1                 asynchronous active-low reset
//   OPB_ADDR   in   ADDR_W            byte address, stable while RE/WE high
//   OPB_RE     in   1                 read request, held until OPB_ACK
//   OPB_WE     in   1                 write request, held until OPB_ACK
//   OPB_DO     out  DATA_W            registered read data, valid with OPB_ACK
//   OPB_ACK    out  1                 one-cycle transfer-complete pulse
//   OPB_ERR    out  1                 one-cycle error pulse, with OPB_ACK
//   SLV_RE     out  N_REGIONS         one-hot read strobe, one cycle
//   SLV_WE     out  N_REGIONS         one-hot write strobe, one cycle
//   SLV_ACK    in   N_REGIONS         slave completion (ACK_EN regions only)
//   SLV_RDATA  in   N_REGIONS*DATA_W  packed slave read data, slice i = region i
//   ERR_ADDR   out  ADDR_W            address of the most recent error
//   ERR_CNT    out  8                 saturating error counter
// ---------------------------------------------------------------------------
module opb_region_decoder
    import opb_dec_pkg::*;
#(
    parameter int                          N_REGIONS   = 4,
    parameter int                          ADDR_W      = 32,
    parameter int                          DATA_W      = 32,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h40, 32'h20, 32'h10, 32'h0},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE = {32'h38, 32'h14, 32'h10, 32'h4},
    parameter logic [N_REGIONS-1:0]        ACK_EN      = 4'b0000,
    parameter int                          FIXED_LAT   = 1,
    parameter int                          TIMEOUT     = 255
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [ADDR_W-1:0]             OPB_ADDR,
    input  logic                          OPB_RE,
    input  logic                          OPB_WE,
    output logic [DATA_W-1:0]             OPB_DO,
    output logic                          OPB_ACK,
    output logic                          OPB_ERR,
    output logic [N_REGIONS-1:0]          SLV_RE,
    output logic [N_REGIONS-1:0]          SLV_WE,
    input  logic [N_REGIONS-1:0]          SLV_ACK,
    input  logic [N_REGIONS*DATA_W-1:0]   SLV_RDATA,
    output logic [ADDR_W-1:0]             ERR_ADDR,
    output logic [ERR_CNT_W-1:0]          ERR_CNT
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    localparam logic [TIMER_W-1:0]   FIXED_LAST   = TIMER_W'(FIXED_LAT - 1);
    localparam logic [TIMER_W-1:0]   TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX  = '1;

    // -----------------------------------------------------------------------
    // Region match and priority encode (lowest index wins on overlap)
    // -----------------------------------------------------------------------
    logic [N_REGIONS-1:0] hit_vec;

    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_match
        opb_region_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .addr (OPB_ADDR),
            .base (REGION_BASE[slice_lo(gi, ADDR_W) +: ADDR_W]),
            .size (REGION_SIZE[slice_lo(gi, ADDR_W) +: ADDR_W]),
            .hit  (hit_vec[gi])
        );
    end

    logic [IDX_W-1:0] hit_idx;
    logic             any_hit;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        // Scan from the top so the lowest matching index is the last written.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered transfer context
    // -----------------------------------------------------------------------
    state_t               state;
    logic [ADDR_W-1:0]    addr_q;
    logic                 rd_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TIMER_W-1:0]   timer;

    // Per-transfer view of the selected slave, always from the registered
    // index so address changes mid-transfer cannot redirect it.
    logic                 sel_ack_en;
    logic                 sel_ack;
    logic [DATA_W-1:0]    sel_rdata;

    assign sel_ack_en = ACK_EN[idx_q];
    assign sel_ack    = SLV_ACK[idx_q];
    assign sel_rdata  = SLV_RDATA[slice_lo(int'(idx_q), DATA_W) +: DATA_W];

    // -----------------------------------------------------------------------
    // Transition conditions
    // -----------------------------------------------------------------------
    logic              req;
    logic              idle_err;
    logic              wait_done;
    logic              wait_err;
    logic              enter_err;
    logic              err_rd;
    logic [ADDR_W-1:0] err_addr_src;

    assign req       = OPB_RE | OPB_WE;
    assign idle_err  = (state == ST_IDLE) && req && ((OPB_RE && OPB_WE) || !any_hit);
    // An ack arriving in the same cycle the timer expires still wins.
    assign wait_done = (state == ST_WAIT) &&
                       (sel_ack_en ? sel_ack : (timer == FIXED_LAST));
    assign wait_err  = (state == ST_WAIT) && sel_ack_en && !sel_ack &&
                       (timer == TIMEOUT_LAST);
    assign enter_err = idle_err | wait_err;

    // An IDLE error has not been captured yet, so take the live request.
    assign err_rd       = (state == ST_IDLE) ? OPB_RE   : rd_q;
    assign err_addr_src = (state == ST_IDLE) ? OPB_ADDR : addr_q;

    // -----------------------------------------------------------------------
    // FSM with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            idx_q    <= '0;
            timer    <= '0;
            OPB_DO   <= '0;
            OPB_ACK  <= 1'b0;
            OPB_ERR  <= 1'b0;
            SLV_RE   <= '0;
            SLV_WE   <= '0;
            ERR_ADDR <= '0;
            ERR_CNT  <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            SLV_RE  <= '0;
            SLV_WE  <= '0;
            OPB_ACK <= 1'b0;
            OPB_ERR <= 1'b0;

            if (enter_err) begin
                OPB_ACK  <= 1'b1;
                OPB_ERR  <= 1'b1;
                ERR_ADDR <= err_addr_src;
                if (ERR_CNT != ERR_CNT_MAX) begin
                    ERR_CNT <= ERR_CNT + 1'b1;
                end
                if (err_rd) begin
                    OPB_DO <= '0;
                end
            end

            if (wait_done) begin
                OPB_ACK <= 1'b1;
                // Writes leave the last read data on the bus.
                if (rd_q) begin
                    OPB_DO <= sel_rdata;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= OPB_ADDR;
                        rd_q   <= OPB_RE;
                        idx_q  <= hit_idx;
                        if (idle_err) begin
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_STROBE;
                            if (OPB_RE) begin
                                SLV_RE <= N_REGIONS'(region_onehot(int'(hit_idx)));
                            end else begin
                                SLV_WE <= N_REGIONS'(region_onehot(int'(hit_idx)));
                            end
                        end
                    end
                end

                ST_STROBE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (wait_done) begin
                        state <= ST_DONE;
                    end else if (wait_err) begin
                        state <= ST_ERROR;
                    end
                end

                ST_DONE:  state <= ST_HOLD;
                ST_ERROR: state <= ST_HOLD;

                ST_HOLD: begin
                    if (!OPB_RE && !OPB_WE) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : opb_region_decoder

// File: tb/tb_opb_region_decoder.sv
// ---------------------------------------------------------------------------
// tb_opb_region_decoder
// Self-checking bench for opb_region_decoder. Region 3 is configured as an
// ack-driven region with a timeout of 8; regions 0..2 use fixed latency 1.
// Expected behaviour comes from a transaction-level model: region lookup by
// address range, then latency / error / data rules per transfer.
// ---------------------------------------------------------------------------
module tb_opb_region_decoder;

    localparam int          TIMEOUT_TB = 8;
    localparam int          FIXED_TB   = 1;
    localparam logic [3:0]  ACK_EN_TB  = 4'b1000;
    localparam int unsigned BASE_TB [4] = '{32'h00, 32'h10, 32'h20, 32'h40};
    localparam int unsigned SIZE_TB [4] = '{32'h04, 32'h10, 32'h14, 32'h38};

    logic         clk;
    logic         rst_n;
    logic [31:0]  opb_addr;
    logic         opb_re;
    logic         opb_we;
    logic [31:0]  opb_do;
    logic         opb_ack;
    logic         opb_err;
    logic [3:0]   slv_re;
    logic [3:0]   slv_we;
    logic [3:0]   slv_ack;
    logic [127:0] slv_rdata;
    logic [31:0]  err_addr;
    logic [7:0]   err_cnt;

    logic [31:0]  rdata [4];

    assign slv_rdata = {rdata[3], rdata[2], rdata[1], rdata[0]};

    opb_region_decoder #(
        .N_REGIONS   (4),
        .ADDR_W      (32),
        .DATA_W      (32),
        .REGION_BASE ({32'h40, 32'h20, 32'h10, 32'h0}),
        .REGION_SIZE ({32'h38, 32'h14, 32'h10, 32'h4}),
        .ACK_EN      (4'b1000),
        .FIXED_LAT   (1),
        .TIMEOUT     (8)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .OPB_ADDR  (opb_addr),
        .OPB_RE    (opb_re),
        .OPB_WE    (opb_we),
        .OPB_DO    (opb_do),
        .OPB_ACK   (opb_ack),
        .OPB_ERR   (opb_err),
        .SLV_RE    (slv_re),
        .SLV_WE    (slv_we),
        .SLV_ACK   (slv_ack),
        .SLV_RDATA (slv_rdata),
        .ERR_ADDR  (err_addr),
        .ERR_CNT   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    logic [31:0] model_do;
    logic [31:0] model_eaddr;
    int          model_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest-index region whose byte range contains a, or -1.
    function automatic int model_region(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (SIZE_TB[i] != 0 &&
                longint'(a) >= longint'(BASE_TB[i]) &&
                longint'(a) <  longint'(BASE_TB[i]) + longint'(SIZE_TB[i]))
                return i;
        end
        return -1;
    endfunction

    // One complete OPB transfer. Called #1 after a rising edge; the request
    // is sampled on the next edge (cycle 0), observations are numbered from
    // cycle 1. ack_at = wait cycle in which region 3 acks (0 = never).
    task automatic xfer(input logic [31:0] a, input logic re, input logic we,
                        input int ack_at, input int hold);
        int         r;
        logic       exp_err;
        int         exp_ack_cyc;
        logic [7:0] exp_strobe;
        int         exp_strobe_cyc;
        logic [7:0] strobe_vec;
        int         strobe_cyc;
        int         strobe_cnt;
        int         ack_cyc;
        int         extra;
        logic       err_seen;
        logic [31:0] do_seen;

        r          = model_region(a);
        exp_strobe = '0;
        exp_err    = 1'b0;
        if ((re && we) || r < 0) begin
            exp_err     = 1'b1;
            exp_ack_cyc = 1;
        end else begin
            exp_strobe = re ? 8'(1 << r) : 8'(1 << (r + 4));
            if (ACK_EN_TB[r]) begin
                if (ack_at >= 1 && ack_at <= TIMEOUT_TB) begin
                    exp_ack_cyc = ack_at + 2;
                end else begin
                    exp_err     = 1'b1;
                    exp_ack_cyc = TIMEOUT_TB + 2;
                end
            end else begin
                exp_ack_cyc = FIXED_TB + 2;
            end
        end
        exp_strobe_cyc = (exp_strobe != 0) ? 1 : 0;

        if (exp_err) begin
            if (model_cnt < 255) model_cnt++;
            model_eaddr = a;
            if (re) model_do = '0;
        end else if (re) begin
            model_do = rdata[r];
        end

        opb_addr   = a;
        opb_re     = re;
        opb_we     = we;
        strobe_vec = '0;
        strobe_cyc = 0;
        strobe_cnt = 0;
        ack_cyc    = 0;
        err_seen   = 1'b0;
        do_seen    = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if ((slv_re | slv_we) != 0) begin
                strobe_cnt++;
                if (strobe_cyc == 0) begin
                    strobe_cyc = c;
                    strobe_vec = {slv_we, slv_re};
                end
            end
            if (opb_ack) begin
                ack_cyc  = c;
                err_seen = opb_err;
                do_seen  = opb_do;
            end
            // Address wander after capture must not matter.
            if (c == 1) opb_addr = $urandom;
            slv_ack[3]   = (ack_at > 0) && (c == ack_at + 1);
            slv_ack[2:0] = 3'($urandom);
            if (ack_cyc != 0) break;
        end

        check("strobe_vec", strobe_vec, exp_strobe);
        check("strobe_cyc", strobe_cyc, exp_strobe_cyc);
        check("strobe_cnt", strobe_cnt, (exp_strobe != 0) ? 1 : 0);
        check("ack_cyc", ack_cyc, exp_ack_cyc);
        check("err", err_seen, exp_err);
        check("do", do_seen, model_do);
        check("err_addr", err_addr, model_eaddr);
        check("err_cnt", err_cnt, model_cnt);

        slv_ack = '0;
        extra   = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (opb_ack || (slv_re | slv_we) != 0) extra++;
        end
        opb_re = 1'b0;
        opb_we = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (opb_ack || (slv_re | slv_we) != 0) extra++;
        end
        check("no_reaccess", extra, 0);
    endtask

    initial begin
        int          acks;
        int          kind;
        logic [31:0] a;
        logic [31:0] pick [12];

        pick = '{32'h00, 32'h03, 32'h04, 32'h10, 32'h1F, 32'h20,
                 32'h33, 32'h34, 32'h3F, 32'h40, 32'h77, 32'h78};
        for (int i = 0; i < 4; i++) rdata[i] = 32'hA5A5_0000 | i;

        rst_n       = 1'b0;
        opb_addr    = '0;
        opb_re      = 1'b0;
        opb_we      = 1'b0;
        slv_ack     = '0;
        model_do    = '0;
        model_eaddr = '0;
        model_cnt   = 0;

        #2;
        check("rst_ack", opb_ack, 1'b0);
        check("rst_err", opb_err, 1'b0);
        check("rst_strobes", {slv_we, slv_re}, 8'h00);
        check("rst_do", opb_do, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_err_cnt", err_cnt, 8'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence
        xfer(32'h14, 1'b1, 1'b0, 0, 0);       // region 1 read
        check("rd14_data", opb_do, 32'hA5A5_0001);
        xfer(32'h24, 1'b0, 1'b1, 0, 10);      // region 2 write, long hold
        xfer(32'h34, 1'b1, 1'b0, 0, 0);       // gap -> error
        xfer(32'h33, 1'b1, 1'b0, 0, 0);       // last byte of region 2
        xfer(32'h78, 1'b1, 1'b0, 0, 0);       // one past region 3
        xfer(32'h40, 1'b1, 1'b0, 0, 0);       // ack region, never acks
        xfer(32'h40, 1'b1, 1'b0, 8, 0);       // ack in last wait cycle
        xfer(32'h44, 1'b0, 1'b1, 3, 2);       // ack-region write
        xfer(32'h10, 1'b1, 1'b1, 0, 0);       // RE+WE collision

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) rdata[i] = $urandom;
            a    = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 11)]
                                               : 32'($urandom_range(0, 127));
            kind = $urandom_range(0, 9);
            xfer(a, kind < 5 || kind == 9, kind >= 5, $urandom_range(0, 10),
                 $urandom_range(0, 3));
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            xfer(32'h100 + 32'(n), 1'b1, 1'b0, 0, 0);
        end
        check("err_cnt_sat", err_cnt, 8'd255);

        // Reset in the middle of a WAIT
        opb_addr = 32'h40;
        opb_re   = 1'b1;
        slv_ack  = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", opb_ack, 1'b0);
        check("mid_rst_err", opb_err, 1'b0);
        check("mid_rst_strobes", {slv_we, slv_re}, 8'h00);
        check("mid_rst_do", opb_do, 32'h0);
        check("mid_rst_err_addr", err_addr, 32'h0);
        check("mid_rst_err_cnt", err_cnt, 8'h0);
        opb_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (opb_ack || (slv_re | slv_we) != 0) acks++;
        end
        check("post_rst_quiet", acks, 0);
        model_do    = '0;
        model_eaddr = '0;
        model_cnt   = 0;
        rdata[0]    = 32'h0BAD_F00D;
        xfer(32'h00, 1'b1, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_opb_region_decoder

// File: doc/opb_region_decoder.md
Name: opb_region_decoder

Overview:
- Parametrised, registered successor to the combinational OPB address decoder. N table-driven regions (base/size per region) replace the fixed per-peripheral compares.
- Adds strobed slave selects, per-region ack-or-fixed-latency handshake, a read-data return mux, and error detection: unmapped address, RE+WE collision, ack timeout.
- Sits between the OPB master interface and all peripheral blocks (scratch pad, OSC, LED, DIO, ADC, CAN, ...).

Parameters:
- N_REGIONS, 4, number of decoded regions (1..32)
- ADDR_W, 32, OPB address width
- DATA_W, 32, read data width
- REGION_BASE, {32'h40,32'h20,32'h10,32'h0}, packed N_REGIONS*ADDR_W bases; region i at slice i
- REGION_SIZE, {32'h38,32'h14,32'h10,32'h4}, packed sizes in bytes; size 0 disables the region
- ACK_EN, 4'b0000, bit i=1: region i ends on SLV_ACK[i]; bit i=0: fixed ack after FIXED_LAT cycles
- FIXED_LAT, 1, wait cycles for fixed-latency regions (1..15)
- TIMEOUT, 255, max wait cycles for ACK_EN regions (1..255)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- OPB_ADDR  in  ADDR_W  byte address, held stable by master while RE/WE high
- OPB_RE  in  1  read request, held until OPB_ACK
- OPB_WE  in  1  write request, held until OPB_ACK
- OPB_DO  out  DATA_W  registered read data, valid with OPB_ACK
- OPB_ACK  out  1  one-cycle transfer-complete pulse
- OPB_ERR  out  1  one-cycle error pulse, coincident with OPB_ACK
- SLV_RE  out  N_REGIONS  one-hot read strobe, one cycle
- SLV_WE  out  N_REGIONS  one-hot write strobe, one cycle
- SLV_ACK  in  N_REGIONS  slave completion, sampled only for ACK_EN regions
- SLV_RDATA  in  N_REGIONS*DATA_W  packed slave read data
- ERR_ADDR  out  ADDR_W  address of the most recent error
- ERR_CNT  out  8  saturating error counter

Behaviour:
- Reset (async, RST_N=0): state IDLE. All outputs 0, ERR_CNT=0, timers 0. Reset mid-transfer aborts the transfer; no strobe, ack, or error is issued.
- Hit: base_i <= addr < base_i+size_i, evaluated at ADDR_W+1 bits so base+size never wraps. Overlapping regions: lowest index wins. Size 0 never hits.
- IDLE: on (RE|WE), register addr, direction, hit index and hit flag.
  - RE&WE both high, or no hit -> ERROR.
  - Otherwise -> STROBE.
- STROBE: assert SLV_RE[i] or SLV_WE[i] for exactly 1 cycle -> WAIT. Clear timer.
- WAIT:
  - Fixed region: after FIXED_LAT cycles -> DONE.
  - ACK_EN region: SLV_ACK[i]=1 -> DONE. SLV_ACK[i] high in the same cycle the timer reaches TIMEOUT -> DONE (ack wins).
  - Timer reaching TIMEOUT without ack -> ERROR.
  - SLV_ACK bits of non-selected regions are ignored.
- DONE: OPB_ACK=1 for 1 cycle. For reads, OPB_DO <= SLV_RDATA slice i, captured on the DONE-entry edge. For writes, OPB_DO holds its previous value -> HOLD.
- ERROR: OPB_ACK=1, OPB_ERR=1 for 1 cycle. ERR_ADDR <= addr. ERR_CNT += 1, saturating at 255. For reads, OPB_DO=0 -> HOLD.
- HOLD: wait for RE=0 and WE=0 -> IDLE. Prevents a re-access while the master is still holding the request.
- Latency, fixed region, FIXED_LAT=1: request sampled at edge 0 -> strobe cycle 1 -> wait cycle 2 -> ACK cycle 3.
- Error latency: ACK+ERR in the cycle after the request is sampled.
- Changes to OPB_ADDR during a transfer are ignored; the registered copy is used.

Decomposition:
- Shared package opb_dec_pkg: state encoding (IDLE, STROBE, WAIT, DONE, ERROR, HOLD), timer width, ERR_CNT width, region-slice helper functions.
- Sub-module opb_region_match: purely combinational, one per region via generate. Inputs addr, base, size; output hit. A priority encoder in the parent produces the index.

Test Plan:
- Default map, read 0x14 (region 1), fixed latency 1 -> SLV_RE=4'b0010 for one cycle in cycle 1; OPB_ACK in cycle 3; OPB_DO = slave1 data 0xA5A5_0001; OPB_ERR=0.
- Write 0x24 -> SLV_WE=4'b0100 single cycle. Master holds WE 10 cycles after ACK -> no second strobe; IDLE only after WE falls.
- Read 0x34 (gap between LED end 0x34 and DIO base 0x40) -> no strobe; ACK+ERR next cycle; ERR_ADDR=0x34; ERR_CNT=1; OPB_DO=0. Boundary check: 0x33 hits region 2, 0x78 misses region 3.
- ACK_EN=4'b1000, TIMEOUT=8, read 0x40 with SLV_ACK held 0 -> ERR after 8 wait cycles. Repeat with SLV_ACK[3] in wait cycle 8 -> normal ACK, no ERR.
- RE and WE both high at 0x10 -> no strobe, ERR. 300 further errors -> ERR_CNT saturates at 255.
- Assert RST_N low during WAIT -> outputs 0 immediately; after release, no ACK appears; next read 0x00 completes normally.
